// File: rtl/control_unit_useq.sv
// Microcoded multi-cycle control unit: a writable store supplies per-opcode control words,
// with single-step advance, a terminal halt state and a sticky runaway-phase error flag.
module control_unit_useq #(
   parameter  int OPCODE_W   = 6,
   parameter  int CTRL_W     = 47,
   parameter  int MAX_PHASES = 8,
   localparam int PH_W       = $clog2(MAX_PHASES),
   localparam int ADDR_W     = OPCODE_W + PH_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] OPCode,
   input  logic                run_mode,
   input  logic                subiu,
   input  logic                desceu,
   input  logic                cfg_we,
   input  logic                cfg_fetch,
   input  logic [ADDR_W-1:0]   cfg_addr,
   input  logic [CTRL_W+1:0]   cfg_data,
   output logic [CTRL_W-1:0]   ControlSignals,
   output logic [1:0]          state_o,
   output logic [PH_W-1:0]     phase,
   output logic                instr_done,
   output logic                err
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   typedef enum logic {
      STEP_READY = 1'b0,
      STEP_WAIT  = 1'b1
   } step_t;

   logic [CTRL_W+1:0]   r_store [2**ADDR_W];
   logic [CTRL_W-1:0]   r_fetch_word;
   state_t              r_state;
   state_t              w_state_nxt;
   step_t               r_step;
   step_t               w_step_nxt;
   logic [PH_W-1:0]     r_phase;
   logic [PH_W-1:0]     w_phase_nxt;
   logic [OPCODE_W-1:0] r_opcode_q;
   logic                r_err;
   logic                w_err_set;
   logic                w_adv;
   logic [ADDR_W-1:0]   w_addr;
   logic [CTRL_W+1:0]   w_entry;
   logic                w_last;
   logic                w_halt;
   logic                w_ph_max;

   // Phase 0 reads the live opcode because the latched copy is only captured on that same edge.
   assign w_adv    = run_mode | ((r_step == STEP_READY) & subiu);
   assign w_addr   = (r_phase == '0) ? {OPCode, r_phase} : {r_opcode_q, r_phase};
   assign w_entry  = r_store[w_addr];
   assign w_last   = w_entry[CTRL_W];
   assign w_halt   = w_entry[CTRL_W+1];
   assign w_ph_max = (r_phase == PH_W'(MAX_PHASES - 1));

   assign state_o  = r_state;
   assign phase    = r_phase;
   assign err      = r_err;

   // Control store write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (cfg_we && !cfg_fetch) begin
         r_store[cfg_addr] <= cfg_data;
      end
   end

   // Step handshake next state: a press is accepted only when READY, then a release re-arms.
   always_comb begin
      w_step_nxt = r_step;
      if (run_mode) begin
         w_step_nxt = STEP_READY;
      end else begin
         case (r_step)
            STEP_READY: begin
               if (subiu) w_step_nxt = STEP_WAIT;
               else       w_step_nxt = STEP_READY;
            end
            STEP_WAIT: begin
               if (desceu) w_step_nxt = STEP_READY;
               else        w_step_nxt = STEP_WAIT;
            end
            default: w_step_nxt = STEP_READY;
         endcase
      end
   end

   // Sequencer next state and datapath outputs; nothing is driven on non-advancing cycles.
   always_comb begin
      w_state_nxt    = r_state;
      w_phase_nxt    = r_phase;
      w_err_set      = 1'b0;
      ControlSignals = '0;
      instr_done     = 1'b0;
      case (r_state)
         ST_FETCH: begin
            if (w_adv) begin
               ControlSignals = r_fetch_word;
               w_state_nxt    = ST_EXEC;
               w_phase_nxt    = '0;
            end else begin
               w_state_nxt    = ST_FETCH;
            end
         end
         ST_EXEC: begin
            if (w_adv) begin
               ControlSignals = w_entry[CTRL_W-1:0];
               if (w_halt) begin
                  w_state_nxt = ST_HALT;
                  instr_done  = 1'b1;
               end else if (w_last || w_ph_max) begin
                  // Running off the last phase without a last bit is forced back to fetch.
                  w_state_nxt = ST_FETCH;
                  w_phase_nxt = '0;
                  instr_done  = 1'b1;
                  w_err_set   = ~w_last;
               end else begin
                  w_phase_nxt = r_phase + PH_W'(1);
               end
            end else begin
               w_state_nxt = ST_EXEC;
            end
         end
         ST_HALT: begin
            w_state_nxt = ST_HALT;
         end
         default: begin
            w_state_nxt = ST_FETCH;
            w_phase_nxt = '0;
         end
      endcase
   end

   // Sequencer, step handshake, opcode latch, error flag and fetch word registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_FETCH;
         r_phase      <= '0;
         r_opcode_q   <= '0;
         r_step       <= STEP_READY;
         r_err        <= 1'b0;
         r_fetch_word <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;
         r_step  <= w_step_nxt;
         if (w_adv && (r_state == ST_EXEC) && (r_phase == '0)) begin
            r_opcode_q <= OPCode;
         end
         if (w_err_set) begin
            r_err <= 1'b1;
         end
         if (cfg_we && cfg_fetch) begin
            r_fetch_word <= cfg_data[CTRL_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_control_unit_useq.sv
// Directed bench for control_unit_useq: a behavioural model is checked every cycle,
// and hand-computed sequences pin the model against the expected microprogram behaviour.
module tb_control_unit_useq;

   localparam int OW = 6;
   localparam int CW = 47;
   localparam int MP = 8;
   localparam int PW = 3;
   localparam int AW = OW + PW;

   logic          clk = 1'b0;
   logic          reset;
   logic [OW-1:0] OPCode;
   logic          run_mode;
   logic          subiu;
   logic          desceu;
   logic          cfg_we;
   logic          cfg_fetch;
   logic [AW-1:0] cfg_addr;
   logic [CW+1:0] cfg_data;
   logic [CW-1:0] ControlSignals;
   logic [1:0]    state_o;
   logic [PW-1:0] phase;
   logic          instr_done;
   logic          err;

   int n_tests = 0;
   int n_fail  = 0;

   control_unit_useq #(.OPCODE_W(OW), .CTRL_W(CW), .MAX_PHASES(MP)) dut (
      .clk(clk), .reset(reset), .OPCode(OPCode), .run_mode(run_mode),
      .subiu(subiu), .desceu(desceu), .cfg_we(cfg_we), .cfg_fetch(cfg_fetch),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .ControlSignals(ControlSignals),
      .state_o(state_o), .phase(phase), .instr_done(instr_done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int            m_state;   // 0 fetch, 1 exec, 2 halt
   int            m_phase;
   int            m_op;
   bit            m_err;
   bit            m_ready;
   logic [CW-1:0] m_fetch;
   logic [CW+1:0] m_mem [0:(1<<AW)-1];

   function automatic void model_reset();
      m_state = 0; m_phase = 0; m_op = 0; m_err = 1'b0; m_ready = 1'b1; m_fetch = '0;
   endfunction

   function automatic bit model_adv();
      return run_mode || (m_ready && subiu);
   endfunction

   function automatic logic [CW+1:0] model_entry();
      int op;
      op = (m_phase == 0) ? int'(OPCode) : m_op;
      return m_mem[op * MP + m_phase];
   endfunction

   function automatic void model_step();
      bit            adv;
      logic [CW+1:0] ent;
      adv = model_adv();
      ent = model_entry();
      if (run_mode)                  m_ready = 1'b1;
      else if (m_ready && subiu)     m_ready = 1'b0;
      else if (!m_ready && desceu)   m_ready = 1'b1;
      if (adv) begin
         if (m_state == 0) begin
            m_state = 1; m_phase = 0;
         end else if (m_state == 1) begin
            if (m_phase == 0) m_op = int'(OPCode);
            if (ent[CW+1])             m_state = 2;
            else if (ent[CW])          begin m_state = 0; m_phase = 0; end
            else if (m_phase == MP-1)  begin m_state = 0; m_phase = 0; m_err = 1'b1; end
            else                       m_phase = m_phase + 1;
         end
      end
      if (cfg_we) begin
         if (cfg_fetch) m_fetch = cfg_data[CW-1:0];
         else           m_mem[int'(cfg_addr)] = cfg_data;
      end
   endfunction

   initial begin
      logic [CW-1:0] e_cs;
      logic [CW+1:0] ent;
      bit            adv;
      bit            e_done;
      for (int i = 0; i < (1<<AW); i++) m_mem[i] = '0;
      model_reset();
      forever begin
         @(negedge clk);
         if (!reset) model_reset();
         adv    = model_adv();
         ent    = model_entry();
         e_cs   = '0;
         e_done = 1'b0;
         if (adv && m_state == 0) e_cs = m_fetch;
         if (adv && m_state == 1) begin
            e_cs   = ent[CW-1:0];
            e_done = ent[CW+1] || ent[CW] || (m_phase == MP-1);
         end
         chk("m_cs",    64'(ControlSignals), 64'(e_cs));
         chk("m_state", 64'(state_o),        64'(m_state));
         chk("m_phase", 64'(phase),          64'(m_phase));
         chk("m_done",  64'(instr_done),     64'(e_done));
         chk("m_err",   64'(err),            64'(m_err));
         @(posedge clk);
         if (!reset) model_reset();
         else        model_step();
      end
   end

   // ---------------- stimulus ----------------
   task automatic wr(input bit f, input int op, input int ph, input logic [CW+1:0] d);
      cfg_we    = 1'b1;
      cfg_fetch = f;
      cfg_addr  = AW'(op * MP + ph);
      cfg_data  = d;
      @(posedge clk); #1;
      cfg_we    = 1'b0;
      cfg_fetch = 1'b0;
   endtask

   task automatic lchk(input string nm, input logic [CW-1:0] e_cs, input logic [1:0] e_st,
                       input logic e_done);
      @(negedge clk);
      chk({nm, "_cs"},   64'(ControlSignals), 64'(e_cs));
      chk({nm, "_st"},   64'(state_o),        64'(e_st));
      chk({nm, "_done"}, 64'(instr_done),     64'(e_done));
      @(posedge clk); #1;
   endtask

   localparam logic [CW+1:0] LAST = {2'b01, 47'h0};
   localparam logic [CW+1:0] HALT = {2'b10, 47'h0};

   initial begin
      reset = 1'b1; run_mode = 1'b0; subiu = 1'b0; desceu = 1'b0; cfg_we = 1'b0;
      cfg_fetch = 1'b0; cfg_addr = '0; cfg_data = '0; OPCode = '0;
      #2 reset = 1'b0;
      #1;
      chk("rst_state", 64'(state_o), 64'd0);
      chk("rst_phase", 64'(phase),   64'd0);
      chk("rst_err",   64'(err),     64'd0);
      chk("rst_cs",    64'(ControlSignals), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      for (int i = 0; i < (1<<AW); i++) wr(1'b0, i / MP, i % MP, '0);
      wr(1'b1, 0, 0, 49'h1);
      wr(1'b0, 5, 0, 49'h10);
      wr(1'b0, 5, 1, LAST | 49'h20);
      wr(1'b0, 3, 0, HALT | LAST | 49'h44);
      for (int p = 0; p < MP; p++) wr(1'b0, 7, p, 49'h100 + 49'(p));

      // free run, opcode latch
      run_mode = 1'b1; OPCode = 6'd5;
      lchk("run_f",  47'h1,  2'd0, 1'b0);
      lchk("run_e0", 47'h10, 2'd1, 1'b0);
      OPCode = 6'd9;
      lchk("latch_e1", 47'h20, 2'd1, 1'b1);
      OPCode = 6'd5;
      lchk("run_f2",  47'h1,  2'd0, 1'b0);
      lchk("run_e0b", 47'h10, 2'd1, 1'b0);
      lchk("run_e1b", 47'h20, 2'd1, 1'b1);

      // single step
      run_mode = 1'b0; subiu = 1'b1;
      lchk("step_press", 47'h1, 2'd0, 1'b0);
      repeat (4) lchk("step_hold", 47'h0, 2'd1, 1'b0);
      subiu = 1'b0; desceu = 1'b1;
      lchk("step_rel", 47'h0, 2'd1, 1'b0);
      desceu = 1'b0; subiu = 1'b1;
      lchk("step_press2", 47'h10, 2'd1, 1'b0);
      chk("step_phase", 64'(phase), 64'd1);
      subiu = 1'b0;
      lchk("step_idle", 47'h0, 2'd1, 1'b0);
      desceu = 1'b1;
      lchk("step_rel2", 47'h0, 2'd1, 1'b0);
      desceu = 1'b0; subiu = 1'b1;
      lchk("step_e1", 47'h20, 2'd1, 1'b1);
      subiu = 1'b0;

      // runaway
      run_mode = 1'b1; OPCode = 6'd7;
      lchk("ra_f", 47'h1, 2'd0, 1'b0);
      for (int p = 0; p < MP; p++) begin
         chk("ra_err_pre", 64'(err), 64'd0);
         lchk("ra_e", 47'h100 + 47'(p), 2'd1, (p == MP-1));
      end
      chk("ra_err", 64'(err), 64'd1);
      chk("ra_wrap_st", 64'(state_o), 64'd0);
      OPCode = 6'd5;
      lchk("sticky_f",  47'h1,  2'd0, 1'b0);
      lchk("sticky_e0", 47'h10, 2'd1, 1'b0);
      lchk("sticky_e1", 47'h20, 2'd1, 1'b1);
      chk("err_sticky", 64'(err), 64'd1);

      // async reset in EXEC phase 2
      OPCode = 6'd7;
      lchk("ar_f",  47'h1,   2'd0, 1'b0);
      lchk("ar_e0", 47'h100, 2'd1, 1'b0);
      lchk("ar_e1", 47'h101, 2'd1, 1'b0);
      chk("ar_pre_phase", 64'(phase), 64'd2);
      #2 reset = 1'b0;
      #1;
      chk("ar_state", 64'(state_o), 64'd0);
      chk("ar_phase", 64'(phase),   64'd0);
      chk("ar_err",   64'(err),     64'd0);
      chk("ar_cs",    64'(ControlSignals), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1; run_mode = 1'b0;
      wr(1'b1, 0, 0, 49'h1);
      run_mode = 1'b1; OPCode = 6'd5;
      lchk("post_f",  47'h1,  2'd0, 1'b0);
      lchk("post_e0", 47'h10, 2'd1, 1'b0);
      lchk("post_e1", 47'h20, 2'd1, 1'b1);

      // halt
      OPCode = 6'd3;
      lchk("halt_f",  47'h1,  2'd0, 1'b0);
      lchk("halt_e0", 47'h44, 2'd1, 1'b1);
      subiu = 1'b1;
      repeat (3) lchk("halt_run", 47'h0, 2'd2, 1'b0);
      run_mode = 1'b0;
      for (int i = 0; i < 4; i++) begin
         subiu  = ((i % 2) == 0);
         desceu = ((i % 2) == 1);
         lchk("halt_step", 47'h0, 2'd2, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
